// File: rtl/dbus2apb_pkg.sv
// Shared bus definitions for the data-bus to APB3 bridge: FSM encoding,
// APB widths and the word-alignment helper.
package dbus2apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // APB transfers are word-only; any set low address bit is rejected.
   function automatic logic word_aligned(input logic [1:0] low_bits);
      return (low_bits == 2'b00);
   endfunction

endpackage

// File: rtl/dbus2apb.sv
// Core data-bus to APB3 master bridge: one outstanding transfer, wait-state
// timeout, misaligned requests answered locally with an error response.
module dbus2apb
   import dbus2apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESETN,
   input  logic                  dbus_req,
   input  logic                  dbus_we,
   input  logic [APB_ADDR_W-1:0] dbus_addr,
   input  logic [APB_DATA_W-1:0] dbus_wdata,
   output logic                  dbus_gnt,
   output logic                  dbus_rsp_valid,
   output logic [APB_DATA_W-1:0] dbus_rdata,
   output logic                  dbus_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [APB_ADDR_W-1:0] PADDR,
   output logic [APB_DATA_W-1:0] PWDATA,
   input  logic [APB_DATA_W-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
   localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);
   localparam logic [CNT_W:0] ONE   = {{CNT_W{1'b0}}, 1'b1};

   apb_state_e       state;
   apb_state_e       next_state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W:0]   cnt_inc;
   logic             timeout_hit;
   logic             accept_ok;
   logic             reject;
   logic             finish_ok;
   logic             abort;

   assign dbus_gnt = (state == IDLE);

   // The extra top bit of cnt_inc flags saturation, so the counter never wraps.
   assign cnt_inc     = {1'b0, wait_cnt} + ONE;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == LIMIT);

   always_comb begin
      next_state = state;
      accept_ok  = 1'b0;
      reject     = 1'b0;
      finish_ok  = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (dbus_req) begin
               if (word_aligned(dbus_addr[1:0])) begin
                  accept_ok  = 1'b1;
                  next_state = SETUP;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         SETUP: begin
            next_state = ACCESS;
         end
         ACCESS: begin
            // A ready slave beats a timeout that expires in the same cycle.
            if (PREADY) begin
               finish_ok  = 1'b1;
               next_state = IDLE;
            end else if (timeout_hit) begin
               abort      = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state   <= IDLE;
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
      end else begin
         state   <= next_state;
         PSEL    <= (next_state != IDLE);
         PENABLE <= (next_state == ACCESS);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         PADDR  <= '0;
         PWDATA <= '0;
         PWRITE <= 1'b0;
      end else if (accept_ok) begin
         PADDR  <= dbus_addr;
         PWDATA <= dbus_wdata;
         PWRITE <= dbus_we;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         wait_cnt <= '0;
      end else if (state == SETUP) begin
         wait_cnt <= '0;
      end else if ((state == ACCESS) && !PREADY && !cnt_inc[CNT_W]) begin
         wait_cnt <= cnt_inc[CNT_W-1:0];
      end
   end

   // Response data and error hold their value between pulses.
   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         dbus_rsp_valid <= 1'b0;
         dbus_err       <= 1'b0;
         dbus_rdata     <= '0;
      end else begin
         dbus_rsp_valid <= finish_ok | abort | reject;
         if (finish_ok) begin
            dbus_err   <= PSLVERR;
            dbus_rdata <= PWRITE ? '0 : PRDATA;
         end else if (abort || reject) begin
            dbus_err   <= 1'b1;
            dbus_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dbus2apb.sv
// Self-checking bench for dbus2apb: directed vector table, reset corner case,
// and randomized transfers checked against a transaction-level model.
module tb_dbus2apb;

   localparam int TO = 4;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        PCLK;
   logic        PRESETN;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic        dbus_gnt;
   logic        dbus_rsp_valid;
   logic [31:0] dbus_rdata;
   logic        dbus_err;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int          tests_run;
   int          tests_failed;
   logic [31:0] last_rdata;
   logic        last_err;

   dbus2apb #(.TIMEOUT_CYCLES(TO)) dut (
      .PCLK           (PCLK),
      .PRESETN        (PRESETN),
      .dbus_req       (dbus_req),
      .dbus_we        (dbus_we),
      .dbus_addr      (dbus_addr),
      .dbus_wdata     (dbus_wdata),
      .dbus_gnt       (dbus_gnt),
      .dbus_rsp_valid (dbus_rsp_valid),
      .dbus_rdata     (dbus_rdata),
      .dbus_err       (dbus_err),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PADDR          (PADDR),
      .PWDATA         (PWDATA),
      .PRDATA         (PRDATA),
      .PREADY         (PREADY),
      .PSLVERR        (PSLVERR)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic vec_t mkvec(input string name, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int waits,
                                  input logic [31:0] prdata, input logic slverr,
                                  input int lat, input logic err, input logic [31:0] rdata);
      vec_t v;
      v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.waits = waits;
      v.prdata = prdata; v.slverr = slverr;
      v.exp_lat = lat; v.exp_err = err; v.exp_rdata = rdata;
      return v;
   endfunction

   // Transaction-level reference: outcome and latency follow from alignment,
   // the slave's wait count versus the timeout, and the access direction.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.addr[1:0] != 2'b00) begin
         r.exp_lat = 1; r.exp_err = 1'b1; r.exp_rdata = 32'h0;
      end else if (TO != 0 && v.waits >= TO) begin
         r.exp_lat = 2 + TO; r.exp_err = 1'b1; r.exp_rdata = 32'h0;
      end else begin
         r.exp_lat = 3 + v.waits; r.exp_err = v.slverr;
         r.exp_rdata = v.we ? 32'h0 : v.prdata;
      end
      return r;
   endfunction

   // Issues one request in the current cycle and plays the APB slave; the
   // slave raises PREADY after v.waits ACCESS cycles. Returns in the response
   // cycle so the caller may issue a back-to-back request immediately.
   task automatic apply_stimulus(input vec_t v);
      logic aligned;
      logic in_xfer;
      int   c;
      aligned = (v.addr[1:0] == 2'b00);
      check_output({v.name, "_gnt_start"}, {31'h0, dbus_gnt}, 32'h1);
      dbus_req   = 1'b1;
      dbus_we    = v.we;
      dbus_addr  = v.addr;
      dbus_wdata = v.wdata;
      PREADY     = 1'b0;
      c = 0;
      while (c < v.exp_lat) begin
         tick();
         c++;
         dbus_req   = 1'b0;
         dbus_addr  = $urandom;
         dbus_wdata = $urandom;
         if (c == 2 + v.waits) begin
            PREADY = 1'b1; PRDATA = v.prdata; PSLVERR = v.slverr;
         end else begin
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
         end
         in_xfer = aligned && (c < v.exp_lat);
         check_output({v.name, "_psel"}, {31'h0, PSEL}, {31'h0, in_xfer});
         check_output({v.name, "_penable"}, {31'h0, PENABLE}, {31'h0, in_xfer && c >= 2});
         check_output({v.name, "_gnt"}, {31'h0, dbus_gnt}, {31'h0, !in_xfer});
         check_output({v.name, "_rsp_valid"}, {31'h0, dbus_rsp_valid},
                      {31'h0, c == v.exp_lat});
         if (in_xfer) begin
            check_output({v.name, "_paddr"}, PADDR, v.addr);
            check_output({v.name, "_pwdata"}, PWDATA, v.wdata);
            check_output({v.name, "_pwrite"}, {31'h0, PWRITE}, {31'h0, v.we});
         end
      end
      check_output({v.name, "_rdata"}, dbus_rdata, v.exp_rdata);
      check_output({v.name, "_err"}, {31'h0, dbus_err}, {31'h0, v.exp_err});
      PREADY     = 1'b0;
      last_rdata = v.exp_rdata;
      last_err   = v.exp_err;
   endtask

   task automatic idle_check(input string name);
      tick();
      check_output({name, "_rsp_low"}, {31'h0, dbus_rsp_valid}, 32'h0);
      check_output({name, "_rdata_hold"}, dbus_rdata, last_rdata);
      check_output({name, "_err_hold"}, {31'h0, dbus_err}, {31'h0, last_err});
      check_output({name, "_psel_idle"}, {31'h0, PSEL}, 32'h0);
   endtask

   vec_t vecs[10];
   vec_t rv;
   vec_t hv;

   initial begin
      logic [31:0] r;
      tests_run    = 0;
      tests_failed = 0;
      last_rdata   = 32'h0;
      last_err     = 1'b0;
      PRESETN      = 1'b0;
      dbus_req     = 1'b0;
      dbus_we      = 1'b0;
      dbus_addr    = 32'h0;
      dbus_wdata   = 32'h0;
      PRDATA       = 32'h0;
      PREADY       = 1'b0;
      PSLVERR      = 1'b0;

      #2;
      check_output("reset_psel", {31'h0, PSEL}, 32'h0);
      check_output("reset_penable", {31'h0, PENABLE}, 32'h0);
      check_output("reset_pwrite", {31'h0, PWRITE}, 32'h0);
      check_output("reset_paddr", PADDR, 32'h0);
      check_output("reset_pwdata", PWDATA, 32'h0);
      check_output("reset_rsp_valid", {31'h0, dbus_rsp_valid}, 32'h0);
      check_output("reset_err", {31'h0, dbus_err}, 32'h0);
      check_output("reset_rdata", dbus_rdata, 32'h0);
      tick();
      tick();
      PRESETN = 1'b1;
      check_output("reset_release_gnt", {31'h0, dbus_gnt}, 32'h1);

      vecs[0] = mkvec("rd_ok",        0, 32'h0000_1004, 32'h0,         0, 32'hDEAD_BEEF, 0, 3, 0, 32'hDEAD_BEEF);
      vecs[1] = mkvec("wr_wait3",     1, 32'h0000_2000, 32'h1234_5678, 3, 32'hA5A5_A5A5, 0, 6, 0, 32'h0);
      vecs[2] = mkvec("rd_slverr",    0, 32'h0000_3008, 32'h0,         1, 32'hCAFE_0001, 1, 4, 1, 32'hCAFE_0001);
      vecs[3] = mkvec("rd_timeout",   0, 32'h0000_4000, 32'h0,         9, 32'h1111_1111, 0, 6, 1, 32'h0);
      vecs[4] = mkvec("rd_rdy_limit", 0, 32'h0000_4004, 32'h0,         3, 32'h0BAD_F00D, 0, 6, 0, 32'h0BAD_F00D);
      vecs[5] = mkvec("misalign_rd",  0, 32'h0000_1002, 32'h0,         0, 32'h2222_2222, 0, 1, 1, 32'h0);
      vecs[6] = mkvec("wr_slverr",    1, 32'h0000_5000, 32'h8765_4321, 0, 32'h3333_3333, 1, 3, 1, 32'h0);
      vecs[7] = mkvec("misalign_wr",  1, 32'h0000_7003, 32'hFFFF_0000, 0, 32'h0,         0, 1, 1, 32'h0);
      vecs[8] = mkvec("rd_b2b_a",     0, 32'h0000_0100, 32'h0,         0, 32'h0123_4567, 0, 3, 0, 32'h0123_4567);
      vecs[9] = mkvec("rd_b2b_b",     0, 32'h0000_0104, 32'h0,         2, 32'h89AB_CDEF, 0, 5, 0, 32'h89AB_CDEF);

      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i]);
      end
      idle_check("after_table");

      // Reset pulsed in the middle of an ACCESS phase drops the transfer.
      hv = mkvec("rst_mid", 0, 32'h0000_6000, 32'h0, 20, 32'h4444_4444, 0, 0, 0, 32'h0);
      check_output("rst_mid_gnt_start", {31'h0, dbus_gnt}, 32'h1);
      dbus_req = 1'b1; dbus_we = hv.we; dbus_addr = hv.addr;
      tick();
      dbus_req = 1'b0;
      tick();
      tick();
      check_output("rst_mid_in_access", {31'h0, PENABLE}, 32'h1);
      PRESETN = 1'b0;
      #1;
      check_output("rst_mid_psel", {31'h0, PSEL}, 32'h0);
      check_output("rst_mid_penable", {31'h0, PENABLE}, 32'h0);
      check_output("rst_mid_paddr", PADDR, 32'h0);
      check_output("rst_mid_rsp", {31'h0, dbus_rsp_valid}, 32'h0);
      tick();
      PRESETN = 1'b1;
      check_output("rst_mid_gnt_release", {31'h0, dbus_gnt}, 32'h1);
      last_rdata = 32'h0;
      last_err   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle_check("rst_mid_quiet");
      end
      apply_stimulus(model(mkvec("rst_recover", 0, 32'h0000_6004, 32'h0, 1, 32'h5555_AAAA, 0, 0, 0, 32'h0)));

      for (int i = 0; i < 40; i++) begin
         r = $urandom;
         rv.name   = $sformatf("rand%0d", i);
         rv.we     = 1'($urandom);
         rv.addr   = {r[31:2], ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
         rv.wdata  = $urandom;
         rv.waits  = $urandom_range(0, 6);
         rv.prdata = $urandom;
         rv.slverr = ($urandom_range(0, 3) == 0);
         rv = model(rv);
         apply_stimulus(rv);
         if ($urandom_range(0, 2) == 0) begin
            idle_check({rv.name, "_gap"});
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
